cw310_crypt_seq: RTL and testbench

Batch-mode crypto sequencer between the CW310 register block and a block-cipher core (e.g. `aes_core`). From a single start pulse it runs a programmable number of back-to-back encryptions, optionally chaining ciphertext into the next plaintext. It also generates a delay-programmable capture trigger per block and reports progress, completion and (optionally) core timeout. It generalises the fixed one-block `load`/`busy` hookup to arbitrary data, key and batch widths.

---
 rtl/cw310_crypt_seq.sv | 155 +++++++++++++++
 tb/tb_cw310_crypt_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cw310_crypt_seq.sv
// cw310_crypt_seq: batch block-cipher sequencer with chaining, delayed capture trigger,
// progress/done reporting; optional per-block core timeout under `CRYPT_SEQ_TIMEOUT_EN`.
module cw310_crypt_seq #(
    parameter int pPT_WIDTH    = 128,
    parameter int pCT_WIDTH    = 128,
    parameter int pKEY_WIDTH   = 128,
    parameter int pBATCH_WIDTH = 16,
    parameter int pDLY_WIDTH   = 8,
    parameter int pTIMEOUT     = 1024
) (
    input  logic                    crypto_clk,
    input  logic                    resetn,
    input  logic                    start_i,
    input  logic [pBATCH_WIDTH-1:0] batch_cnt_i,
    input  logic                    chain_i,
    input  logic                    trig_all_i,
    input  logic [pDLY_WIDTH-1:0]   trig_dly_i,
    input  logic [pKEY_WIDTH-1:0]   key_i,
    input  logic [pPT_WIDTH-1:0]    text_i,
    output logic                    core_load_o,
    output logic [pKEY_WIDTH-1:0]   core_key_o,
    output logic [pPT_WIDTH-1:0]    core_text_o,
    input  logic [pCT_WIDTH-1:0]    core_ct_i,
    input  logic                    core_busy_i,
    output logic [pCT_WIDTH-1:0]    ct_o,
    output logic [pBATCH_WIDTH-1:0] blocks_done_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    trigger_o,
    output logic                    error_o
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_DONE} state_t;

    state_t                  r_state, w_nxt;
    logic [pKEY_WIDTH-1:0]   r_key;
    logic [pPT_WIDTH-1:0]    r_text, r_work;
    logic [pCT_WIDTH-1:0]    r_ct;
    logic [pBATCH_WIDTH-1:0] r_batch, r_done_cnt, w_cnt_inc;
    logic [pDLY_WIDTH-1:0]   r_dly, r_dcnt;
    logic                    r_chain, r_trig_all, r_trig;
    logic                    w_start, w_cap, w_tmo, w_elig;

    assign w_start   = (r_state == S_IDLE) && start_i;
    assign w_cap     = (r_state == S_RUN) && !core_busy_i;
    assign w_cnt_inc = r_done_cnt + 1'b1;
    assign w_elig    = r_trig_all || (r_done_cnt == '0);

    assign core_load_o   = (r_state == S_LOAD);
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = (r_state == S_DONE);
    assign core_key_o    = r_key;
    assign core_text_o   = r_work;
    assign ct_o          = r_ct;
    assign blocks_done_o = r_done_cnt;
    assign trigger_o     = r_trig;

`ifdef CRYPT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo   = (r_state == S_WAIT || r_state == S_RUN) && !w_cap && (r_tmo == TW'(pTIMEOUT - 1));
    assign error_o = r_err;

    // per-block cycle counter restarted by each load; sticky error cleared by the next start
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_LOAD)
                r_tmo <= '0;
            else if (r_state == S_WAIT || r_state == S_RUN)
                r_tmo <= r_tmo + 1'b1;
            if (w_start)
                r_err <= 1'b0;
            else if (w_tmo)
                r_err <= 1'b1;
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign error_o = 1'b0;
`endif

    // state register
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_nxt;
    end

    // next state: a timeout overrides whatever the core is doing
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  w_nxt = start_i ? S_LOAD : S_IDLE;
            S_LOAD:  w_nxt = S_WAIT;
            S_WAIT:  w_nxt = core_busy_i ? S_RUN : S_WAIT;
            S_RUN:   w_nxt = core_busy_i ? S_RUN : (w_cnt_inc == r_batch ? S_DONE : S_LOAD);
            default: w_nxt = S_IDLE;
        endcase
        if (w_tmo)
            w_nxt = S_DONE;
    end

    // batch setup at start, ciphertext capture and next-plaintext selection per block
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_key      <= '0;
            r_text     <= '0;
            r_work     <= '0;
            r_ct       <= '0;
            r_batch    <= '0;
            r_done_cnt <= '0;
            r_chain    <= 1'b0;
            r_trig_all <= 1'b0;
            r_dly      <= '0;
        end else if (w_start) begin
            r_key      <= key_i;
            r_text     <= text_i;
            r_work     <= text_i;
            r_batch    <= (batch_cnt_i == '0) ? pBATCH_WIDTH'(1) : batch_cnt_i;
            r_done_cnt <= '0;
            r_chain    <= chain_i;
            r_trig_all <= trig_all_i;
            r_dly      <= trig_dly_i;
        end else if (w_cap) begin
            r_ct       <= core_ct_i;
            r_done_cnt <= w_cnt_inc;
            if (w_cnt_inc != r_batch)
                r_work <= r_chain ? pPT_WIDTH'(core_ct_i) : r_text;
        end
    end

    // trigger: counts cycles since load; a block that finishes before the delay never fires
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_dcnt <= '0;
            r_trig <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_dcnt <= pDLY_WIDTH'(1);
            if (r_dly == '0 && w_elig)
                r_trig <= 1'b1;
        end else if (w_cap || w_tmo) begin
            r_trig <= 1'b0;
        end else if (r_state == S_WAIT || r_state == S_RUN) begin
            if (r_dcnt != '1)
                r_dcnt <= r_dcnt + 1'b1;
            if (r_dcnt == r_dly && w_elig)
                r_trig <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cw310_crypt_seq.sv
// tb_cw310_crypt_seq: directed scoreboard bench for cw310_crypt_seq with an x+1 behavioural core
module tb_cw310_crypt_seq;
    localparam int W = 128;

    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, chain = 1'b0, trig_all = 1'b0;
    logic [15:0]   batch = '0;
    logic [7:0]    dly = '0;
    logic [W-1:0]  key = '0, text = '0, core_ct = '0;
    logic          core_busy = 1'b0, stuck = 1'b0;
    int            core_lat = 10, m_rem = 0;
    logic          core_load, busy_o, done_o, trigger_o, error_o;
    logic [W-1:0]  core_key, core_text, ct_o;
    logic [15:0]   blocks_done;
    int            total = 0, bad = 0;

    typedef struct packed {logic [W-1:0] ct; logic [15:0] cnt;} res_t;
    res_t          q_res[$];
    logic [W-1:0]  q_text[$];

    always #5 clk = ~clk;

    cw310_crypt_seq #(.pTIMEOUT(64)) dut (
        .crypto_clk(clk), .resetn(resetn), .start_i(start), .batch_cnt_i(batch),
        .chain_i(chain), .trig_all_i(trig_all), .trig_dly_i(dly), .key_i(key), .text_i(text),
        .core_load_o(core_load), .core_key_o(core_key), .core_text_o(core_text),
        .core_ct_i(core_ct), .core_busy_i(core_busy), .ct_o(ct_o), .blocks_done_o(blocks_done),
        .busy_o(busy_o), .done_o(done_o), .trigger_o(trigger_o), .error_o(error_o)
    );

    // behavioural core: busy for core_lat cycles after a load, result = text + 1
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_busy <= 1'b0;
            m_rem <= 0;
        end else if (core_load) begin
            core_busy <= 1'b1;
            m_rem <= core_lat;
            core_ct <= core_text + 1;
        end else if (m_rem > 1)
            m_rem <= m_rem - 1;
        else if (!stuck)
            core_busy <= 1'b0;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_batch(input string tag, input logic [15:0] b, input logic ch, input logic ta,
                             input logic [7:0] d, input logic [W-1:0] k, input logic [W-1:0] tx,
                             input int lat, input int exp_pulses, input int exp_first, input bit abuse);
        int t, pulses, first, dones;
        logic prev;
        logic [15:0] nb;
        res_t r;
        q_text.delete();
        q_res.delete();
        nb = (b == 0) ? 16'd1 : b;
        for (int i = 0; i < int'(nb); i++) q_text.push_back(ch ? tx + W'(i) : tx);
        q_res.push_back({ch ? tx + W'(nb) : tx + W'(1), nb});
        @(negedge clk);
        batch = b; chain = ch; trig_all = ta; dly = d; key = k; text = tx; core_lat = lat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_load_s1"}, W'(core_load), W'(1'b1));
        chk({tag, "_err_clr"}, W'(error_o), W'(1'b0));
        pulses = 0; first = -1; dones = 0; prev = 1'b0;
        for (t = 1; t < 3000 && dones == 0; t++) begin
            if (t > 1) @(negedge clk);
            start = abuse && (t == 5 || t == 9);
            if (core_load)
                chk({tag, "_text"}, core_text, q_text.size() > 0 ? q_text.pop_front() : 'x);
            if (trigger_o && !prev) begin
                pulses++;
                if (first < 0) first = t;
            end
            prev = trigger_o;
            if (done_o) begin
                dones++;
                r = q_res.pop_front();
                chk({tag, "_ct"}, ct_o, r.ct);
                chk({tag, "_blocks"}, W'(blocks_done), W'(r.cnt));
                chk({tag, "_key"}, core_key, k);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, W'(dones), W'(1));
        chk({tag, "_loads"}, W'(q_text.size()), W'(0));
        chk({tag, "_pulses"}, W'(pulses), W'(exp_pulses));
        chk({tag, "_first_trig"}, W'(first), W'(exp_first));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_idle_after"}, W'({busy_o, done_o, trigger_o}), W'(3'b000));
        end
    endtask

    initial begin
        int t;
        logic [W-1:0] ct_keep;
        repeat (3) @(negedge clk);
        chk("reset_ctl", W'({core_load, busy_o, done_o, trigger_o, error_o, blocks_done}), W'(0));
        chk("reset_data", core_key | core_text | ct_o, W'(0));
        resetn = 1'b1;

        run_batch("single", 16'd1, 1'b0, 1'b0, 8'd0, 128'h0f0e0d0c0b0a09080706050403020100,
                  128'h00112233445566778899aabbccddeeff, 10, 1, 2, 1'b0);
        run_batch("chain", 16'd4, 1'b1, 1'b1, 8'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h0, 10, 4, 2, 1'b0);
        run_batch("gate_first", 16'd3, 1'b0, 1'b0, 8'd5, 128'h1, 128'ha5, 10, 1, 7, 1'b0);
        run_batch("gate_all", 16'd3, 1'b0, 1'b1, 8'd5, 128'h2, 128'ha5, 10, 3, 7, 1'b0);
        run_batch("late_dly", 16'd3, 1'b0, 1'b1, 8'd20, 128'h3, 128'h5a, 10, 0, -1, 1'b0);
        run_batch("fast", 16'd2, 1'b0, 1'b1, 8'd1, 128'h4, {W{1'b1}}, 1, 2, 3, 1'b0);
        run_batch("abuse", 16'd0, 1'b0, 1'b0, 8'd0, 128'h5, 128'h77, 10, 1, 2, 1'b1);

        @(negedge clk);
        batch = 16'd5; chain = 1'b1; trig_all = 1'b1; dly = 8'd0; key = 128'hdead; text = 128'h100;
        core_lat = 10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && blocks_done != 16'd1; i++) @(negedge clk);
        chk("rst_reach_blk2", W'(blocks_done), W'(1));
        repeat (4) @(negedge clk);
        chk("rst_pre_trig", W'({busy_o, trigger_o}), W'(2'b11));
        resetn = 1'b0;
        #1;
        chk("rst_mid_ctl", W'({core_load, busy_o, done_o, trigger_o, error_o, blocks_done}), W'(0));
        chk("rst_mid_ct", ct_o, W'(0));
        chk("rst_mid_key", core_key, W'(0));
        chk("rst_mid_text", core_text, W'(0));
        @(negedge clk);
        resetn = 1'b1;
        run_batch("after_rst", 16'd2, 1'b1, 1'b0, 8'd0, 128'hbeef, 128'h40, 3, 1, 2, 1'b0);

        ct_keep = ct_o;
        stuck = 1'b1;
        @(negedge clk);
        batch = 16'd2; trig_all = 1'b1; dly = 8'd0; core_lat = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef CRYPT_SEQ_TIMEOUT_EN
        t = 1;
        while (!done_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_cycle", W'(t), W'(66));
        chk("tmo_err", W'(error_o), W'(1'b1));
        chk("tmo_trig_drop", W'(trigger_o), W'(1'b0));
        chk("tmo_blocks_hold", W'(blocks_done), W'(0));
        chk("tmo_ct_hold", ct_o, ct_keep);
        @(negedge clk);
        chk("tmo_err_sticky", W'({busy_o, error_o}), W'(2'b01));
        stuck = 1'b0;
        repeat (2) @(negedge clk);
`else
        t = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done_o) t++;
        end
        chk("stuck_no_done", W'(t), W'(0));
        chk("stuck_busy", W'({busy_o, error_o}), W'(2'b10));
        chk("stuck_ct_hold", ct_o, ct_keep);
        resetn = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
`endif
        run_batch("recover", 16'd1, 1'b0, 1'b0, 8'd0, 128'h6, 128'h99, 2, 1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
